// File: rtl/vc_arbiter_pkg.sv
// Shared encodings for the VC scheduler: FSM states, VC select values, destination field layout.
package vc_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } arb_state_t;

  localparam logic SEL_VC0 = 1'b0;
  localparam logic SEL_VC1 = 1'b1;

  localparam int DEF_DW     = 10;
  localparam int DEF_WEIGHT = 4;
  localparam int DEF_CNTW   = 8;
  localparam int NUM_DST    = 4;
  // The destination field occupies the top DST_W bits of each word.
  localparam int DST_W      = 2;

  function automatic logic [NUM_DST-1:0] dst_onehot(input logic [DST_W-1:0] dst);
    dst_onehot      = '0;
    dst_onehot[dst] = 1'b1;
  endfunction

endpackage

// File: rtl/vc_arbiter_dst_counter_bank.sv
// Per-destination saturating push counters with a select mux; 1-cycle update, no backpressure.
// Output is forced to zero while reset is held low.
module vc_arbiter_dst_counter_bank
  import vc_arbiter_pkg::*;
#(
  parameter int CNTW = DEF_CNTW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_DST-1:0] push,
  input  logic [1:0]         cnt_sel,
  output logic [CNTW-1:0]    cnt_out
);

  logic [CNTW-1:0] cnt [NUM_DST];

  always_ff @(posedge clk) begin
    for (int d = 0; d < NUM_DST; d++) begin
      if (!reset) begin
        cnt[d] <= '0;
      end else if (push[d] && (cnt[d] != '1)) begin
        cnt[d] <= cnt[d] + CNTW'(1);
      end
    end
  end

  assign cnt_out = reset ? cnt[cnt_sel] : '0;

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC to four-destination scheduler: pop in cycle N, push in N+1, one word per cycle.
// Any destination almost_full stops new pops; the single in-flight word is always delivered.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int WEIGHT = DEF_WEIGHT,
  parameter int CNTW   = DEF_CNTW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vc0_empty,
  input  logic               vc1_empty,
  input  logic [DW-1:0]      vc0_data,
  input  logic [DW-1:0]      vc1_data,
  input  logic [NUM_DST-1:0] dst_afull,
  output logic               vc0_pop,
  output logic               vc1_pop,
  output logic [NUM_DST-1:0] dst_push,
  output logic [DW-1:0]      dst_data,
  input  logic [1:0]         cnt_sel,
  output logic [CNTW-1:0]    cnt_out,
  output logic               idle
);

  localparam int WCW = $clog2(WEIGHT + 1);

  arb_state_t     state;
  logic           in_flight;
  logic           sel;
  logic [WCW-1:0] wcnt;

  logic           eligible;
  logic           gnt0;
  logic           gnt1;
  logic           push_vld;
  logic [DW-1:0]  word;

  // Destination is unknown until the word is read, so any almost_full blocks all pops.
  always_comb begin
    eligible = reset && (state != ST_RESET) && (dst_afull == '0);
    gnt0     = eligible && !vc0_empty && (vc1_empty || (wcnt < WCW'(WEIGHT)));
    gnt1     = eligible && !gnt0 && !vc1_empty;
  end

  assign vc0_pop = gnt0;
  assign vc1_pop = gnt1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RESET;
      in_flight <= 1'b0;
      sel       <= SEL_VC0;
      wcnt      <= '0;
    end else begin
      in_flight <= gnt0 || gnt1;
      sel       <= gnt1 ? SEL_VC1 : SEL_VC0;

      // Starvation bound only accumulates while VC1 actually has work waiting.
      if (vc1_empty || gnt1) begin
        wcnt <= '0;
      end else if (gnt0 && (wcnt < WCW'(WEIGHT))) begin
        wcnt <= wcnt + WCW'(1);
      end

      case (state)
        ST_RESET:  state <= ST_IDLE;
        ST_IDLE:   if (gnt0 || gnt1) state <= ST_ACTIVE;
        ST_ACTIVE: if (!(gnt0 || gnt1) && !in_flight) state <= ST_IDLE;
        default:   state <= ST_RESET;
      endcase
    end
  end

  always_comb begin
    push_vld = reset && in_flight;
    word     = (sel == SEL_VC1) ? vc1_data : vc0_data;
    dst_data = push_vld ? word : '0;
    dst_push = push_vld ? dst_onehot(word[DW-1:DW-DST_W]) : '0;
  end

  assign idle = reset && (state != ST_RESET) && vc0_empty && vc1_empty && !in_flight;

  vc_arbiter_dst_counter_bank #(
    .CNTW(CNTW)
  ) u_cnt_bank (
    .clk     (clk),
    .reset   (reset),
    .push    (dst_push),
    .cnt_sel (cnt_sel),
    .cnt_out (cnt_out)
  );

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter with behavioural source FIFOs (data valid the cycle after a pop).
module tb_vc_arbiter;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          vc0_empty;
  logic          vc1_empty;
  logic [DW-1:0] vc0_data;
  logic [DW-1:0] vc1_data;
  logic [3:0]    dst_afull = 4'b0000;
  logic          vc0_pop;
  logic          vc1_pop;
  logic [3:0]    dst_push;
  logic [DW-1:0] dst_data;
  logic [1:0]    cnt_sel = 2'd0;
  logic [7:0]    cnt_out;
  logic          idle;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem0 [512];
  logic [DW-1:0] mem1 [512];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

  always #5 clk = ~clk;

  assign vc0_empty = (rd0 == wr0);
  assign vc1_empty = (rd1 == wr1);

  always @(posedge clk) begin
    if (vc0_pop) begin
      vc0_data <= mem0[rd0 % 512];
      rd0      <= rd0 + 1;
    end
    if (vc1_pop) begin
      vc1_data <= mem1[rd1 % 512];
      rd1      <= rd1 + 1;
    end
  end

  vc_arbiter #(.DW(DW), .WEIGHT(4), .CNTW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .vc0_empty (vc0_empty),
    .vc1_empty (vc1_empty),
    .vc0_data  (vc0_data),
    .vc1_data  (vc1_data),
    .dst_afull (dst_afull),
    .vc0_pop   (vc0_pop),
    .vc1_pop   (vc1_pop),
    .dst_push  (dst_push),
    .dst_data  (dst_data),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out),
    .idle      (idle)
  );

  task automatic put0(input logic [1:0] d, input logic [7:0] p);
    mem0[wr0 % 512] = {d, p};
    wr0++;
  endtask

  task automatic put1(input logic [1:0] d, input logic [7:0] p);
    mem1[wr1 % 512] = {d, p};
    wr1++;
  endtask

  task automatic test_reset();
    put0(2'd1, 8'hA0);
    put0(2'd2, 8'hA1);
    put1(2'd3, 8'hB0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({vc0_pop, vc1_pop, dst_push, dst_data, cnt_out, idle} !== '0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got pop=%b%b push=%b data=%h cnt=%0d idle=%b exp all zero",
                 i, vc0_pop, vc1_pop, dst_push, dst_data, cnt_out, idle);
      end
    end
    wr0 = rd0;
    wr1 = rd1;
    reset = 1'b1;
    #1;
    total++;
    if (idle !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle got=%b exp=0", idle);
    end
    @(negedge clk);
    total++;
    if (idle !== 1'b1) begin
      bad++;
      $display("FAIL reset_then_idle got=%b exp=1", idle);
    end
  endtask

  task automatic test_vc0_only();
    logic [3:0]    ep [4] = '{4'b0100, 4'b0001, 4'b1000, 4'b0000};
    logic          eo [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [DW-1:0] ed [4] = '{10'h211, 10'h022, 10'h333, 10'h000};
    logic [7:0]    ec [4] = '{8'd1, 8'd0, 8'd1, 8'd1};
    logic          ei [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    put0(2'd2, 8'h11);
    put0(2'd0, 8'h22);
    put0(2'd3, 8'h33);
    #1;
    total++;
    if (vc0_pop !== 1'b1) begin
      bad++;
      $display("FAIL vc0only_first_pop got=%b exp=1", vc0_pop);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({vc0_pop, vc1_pop, dst_push, dst_data, idle} !== {eo[i], 1'b0, ep[i], ed[i], ei[i]}) begin
        bad++;
        $display("FAIL vc0only_cyc%0d got pop=%b%b push=%b data=%h idle=%b exp pop=%b0 push=%b data=%h idle=%b",
                 i, vc0_pop, vc1_pop, dst_push, dst_data, idle, eo[i], ep[i], ed[i], ei[i]);
      end
    end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      total++;
      if (cnt_out !== ec[s]) begin
        bad++;
        $display("FAIL vc0only_cnt%0d got=%0d exp=%0d", s, cnt_out, ec[s]);
      end
    end
  endtask

  task automatic test_weight();
    logic [1:0] pat [17] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                             2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      put0(2'd1, 8'(i));
      put1(2'd1, 8'(8'h80 + i));
    end
    #1;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if ({vc0_pop, vc1_pop} !== pat[i]) begin
        bad++;
        $display("FAIL weight_grant_cyc%0d got=%b exp=%b", i, {vc0_pop, vc1_pop}, pat[i]);
      end
    end
    @(negedge clk);
    cnt_sel = 2'd1;
    #1;
    total++;
    if ({cnt_out, idle} !== {8'd16, 1'b1}) begin
      bad++;
      $display("FAIL weight_drain got cnt=%0d idle=%b exp cnt=16 idle=1", cnt_out, idle);
    end
  endtask

  task automatic test_afull();
    logic [3:0]    ep [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    logic [DW-1:0] ed [5] = '{10'h1C1, 10'h2C2, 10'h3C3, 10'h0C4, 10'h000};
    logic          eo [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    put0(2'd1, 8'hC0);
    put0(2'd1, 8'hC1);
    put0(2'd2, 8'hC2);
    put0(2'd3, 8'hC3);
    put0(2'd0, 8'hC4);
    #1;
    total++;
    if (vc0_pop !== 1'b1) begin
      bad++;
      $display("FAIL afull_first_pop got=%b exp=1", vc0_pop);
    end
    @(negedge clk);
    total++;
    if ({vc0_pop, dst_push, dst_data} !== {1'b1, 4'b0010, 10'h1C0}) begin
      bad++;
      $display("FAIL afull_pre got pop=%b push=%b data=%h exp pop=1 push=0010 data=1c0",
               vc0_pop, dst_push, dst_data);
    end
    dst_afull = 4'b0010;
    #1;
    total++;
    if ({vc0_pop, dst_push} !== {1'b0, 4'b0010}) begin
      bad++;
      $display("FAIL afull_inflight got pop=%b push=%b exp pop=0 push=0010", vc0_pop, dst_push);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({vc0_pop, vc1_pop, dst_push} !== 6'b0) begin
        bad++;
        $display("FAIL afull_stall%0d got pop=%b%b push=%b exp all zero", i, vc0_pop, vc1_pop, dst_push);
      end
    end
    dst_afull = 4'b0000;
    #1;
    total++;
    if (vc0_pop !== 1'b1) begin
      bad++;
      $display("FAIL afull_resume got=%b exp=1", vc0_pop);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({vc0_pop, dst_push, dst_data} !== {eo[i], ep[i], ed[i]}) begin
        bad++;
        $display("FAIL afull_cyc%0d got pop=%b push=%b data=%h exp pop=%b push=%b data=%h",
                 i, vc0_pop, dst_push, dst_data, eo[i], ep[i], ed[i]);
      end
    end
    cnt_sel = 2'd1;
    #1;
    total++;
    if (cnt_out !== 8'd18) begin
      bad++;
      $display("FAIL afull_cnt1 got=%0d exp=18", cnt_out);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    put0(2'd3, 8'hD5);
    @(negedge clk);
    reset = 1'b0;
    cnt_sel = 2'd3;
    #1;
    total++;
    if ({dst_push, dst_data, cnt_out} !== '0) begin
      bad++;
      $display("FAIL resetmid_gate got push=%b data=%h cnt=%0d exp all zero", dst_push, dst_data, cnt_out);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({dst_push, idle} !== {4'b0000, 1'b1}) begin
      bad++;
      $display("FAIL resetmid_after got push=%b idle=%b exp push=0000 idle=1", dst_push, idle);
    end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      #1;
      total++;
      if (cnt_out !== 8'd0) begin
        bad++;
        $display("FAIL resetmid_cnt%0d got=%0d exp=0", s, cnt_out);
      end
    end
  endtask

  task automatic test_saturate();
    int n;
    cnt_sel = 2'd0;
    @(negedge clk);
    for (int i = 0; i < 300; i++) put0(2'd0, 8'(i));
    #1;
    total++;
    if (idle !== 1'b0) begin
      bad++;
      $display("FAIL sat_busy_idle got=%b exp=0", idle);
    end
    for (int k = 1; k <= 101; k++) @(negedge clk);
    total++;
    if (cnt_out !== 8'd100) begin
      bad++;
      $display("FAIL sat_mid_cnt got=%0d exp=100", cnt_out);
    end
    n = 0;
    while (idle !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (idle !== 1'b1) begin
      bad++;
      $display("FAIL sat_drain_timeout got idle=%b exp=1", idle);
    end
    total++;
    if (cnt_out !== 8'd255) begin
      bad++;
      $display("FAIL sat_cnt got=%0d exp=255", cnt_out);
    end
  endtask

  initial begin
    test_reset();
    test_vc0_only();
    test_weight();
    test_afull();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
